// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between I-cache fills and D-cache fills/stores,
// and raises the global pipeline stall while any memory transaction is pending or in flight.
module mem_arbiter #(
  parameter int unsigned WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss,
  input  logic [15:0]                i_addr,
  input  logic                       d_miss,
  input  logic [15:0]                d_addr,
  input  logic                       d_wr,
  input  logic [15:0]                d_wdata,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_data,
  input  logic                       mem_valid,
  output logic [15:0]                fill_data,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic                       i_fill_we,
  output logic                       d_fill_we,
  output logic                       i_done,
  output logic                       d_done,
  output logic                       stall
);

  localparam int unsigned WW = $clog2(WORDS);
  localparam int unsigned CW = WW + 1;
  localparam logic [CW-1:0] NumWords = CW'(WORDS);
  localparam logic [CW-1:0] LastWord = CW'(WORDS - 1);
  localparam logic [15:0] BaseMask = ~16'(2 * WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFillI, StFillD} state_e;

  state_e        r_state;
  logic [CW-1:0] r_icnt;
  logic [CW-1:0] r_rcnt;
  logic [15:0]   r_base;

  logic        w_fill;
  logic        w_issue;
  logic        w_rx;
  logic        w_last;
  logic [15:0] w_req_addr;

  assign w_fill     = (r_state == StFillI) || (r_state == StFillD);
  assign w_issue    = w_fill && (r_icnt < NumWords);
  assign w_rx       = w_fill && mem_valid;
  assign w_last     = w_rx && (r_rcnt == LastWord);
  assign w_req_addr = (d_wr || d_miss) ? d_addr : i_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_icnt  <= '0;
      r_rcnt  <= '0;
      r_base  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (d_wr || d_miss || i_miss) begin
            r_base <= w_req_addr & BaseMask;
          end
          if (d_wr) begin
            r_state <= StWrite;
          end else if (d_miss) begin
            r_state <= StFillD;
          end else if (i_miss) begin
            r_state <= StFillI;
          end
        end
        StWrite: r_state <= StIdle;
        StFillI, StFillD: begin
          if (w_issue) begin
            r_icnt <= r_icnt + 1'b1;
          end
          // The final word may arrive after issue has finished; clearing wins over increment.
          if (w_last) begin
            r_icnt  <= '0;
            r_rcnt  <= '0;
            r_state <= StIdle;
          end else if (w_rx) begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_data = '0;
    fill_word = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    if (r_state == StWrite) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      d_done    = 1'b1;
    end
    if (w_issue) begin
      mem_en   = 1'b1;
      mem_addr = r_base + (16'(r_icnt) << 1);
    end
    if (w_rx) begin
      fill_data = mem_data;
      fill_word = r_rcnt[WW-1:0];
      i_fill_we = (r_state == StFillI);
      d_fill_we = (r_state == StFillD);
      i_done    = w_last && (r_state == StFillI);
      d_done    = w_last && (r_state == StFillD);
    end
  end

  // Gated by reset so the pipeline is not frozen by requests held during reset.
  assign stall = rst && ((r_state != StIdle) || i_miss || d_miss || d_wr);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-latency and gapped memory models, one task per scenario.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_addr;
  logic        d_miss;
  logic [15:0] d_addr;
  logic        d_wr;
  logic [15:0] d_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we;
  logic        d_fill_we;
  logic        i_done;
  logic        d_done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  int          lat = 4;
  bit          gap_mode = 0;
  int          gap_cnt = 0;
  logic        pipe_v [8];
  logic [15:0] pipe_d [8];
  logic [15:0] rq [$];

  mem_arbiter #(.WORDS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_miss    (i_miss),
    .i_addr    (i_addr),
    .d_miss    (d_miss),
    .d_addr    (d_addr),
    .d_wr      (d_wr),
    .d_wdata   (d_wdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .fill_data (fill_data),
    .fill_word (fill_word),
    .i_fill_we (i_fill_we),
    .d_fill_we (d_fill_we),
    .i_done    (i_done),
    .d_done    (d_done),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 16'h0;
    end
    rq.delete();
    gap_cnt   = 0;
    mem_valid = 1'b0;
    mem_data  = 16'h0;
  endtask

  // Start of cycle: drive this cycle's memory response.
  task automatic cyc_begin();
    @(posedge clk);
    #1;
    if (gap_mode) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
        mem_valid = 1'b0;
        mem_data  = 16'h0;
      end else if (rq.size() > 0) begin
        mem_valid = 1'b1;
        mem_data  = rq.pop_front();
        gap_cnt   = 2;
      end else begin
        mem_valid = 1'b0;
        mem_data  = 16'h0;
      end
    end else begin
      mem_valid = pipe_v[0];
      mem_data  = pipe_v[0] ? pipe_d[0] : 16'h0;
      for (int i = 0; i < 7; i++) begin
        pipe_v[i] = pipe_v[i+1];
        pipe_d[i] = pipe_d[i+1];
      end
      pipe_v[7] = 1'b0;
      pipe_d[7] = 16'h0;
    end
  endtask

  // Mid cycle: outputs are settled; capture any read issued this cycle.
  task automatic cyc_mid();
    @(negedge clk);
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      if (gap_mode) begin
        rq.push_back(16'hA000 + {13'd0, mem_addr[3:1]});
      end else begin
        pipe_v[lat-1] = 1'b1;
        pipe_d[lat-1] = 16'hA000 + {13'd0, mem_addr[3:1]};
      end
    end
  endtask

  task automatic test_reset();
    logic [57:0] outs;
    i_miss = 1'b1;
    i_addr = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      cyc_begin();
      cyc_mid();
      outs = {stall, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
              i_fill_we, d_fill_we, i_done, d_done};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c, outs);
      end
    end
    cyc_begin();
    rst = 1'b1;
    cyc_mid();
    checks++;
    if ({stall, mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_idle got={stall,en}=%b exp=10", {stall, mem_en});
    end
    cyc_begin();
    cyc_mid();
    checks++;
    if ({stall, mem_en, mem_addr} !== {2'b11, 16'h1230}) begin
      errors++;
      $display("FAIL reset_release_fill got=%b/%h exp=11/1230", {stall, mem_en}, mem_addr);
    end
    cyc_begin();
    rst    = 1'b0;
    i_miss = 1'b0;
    model_clear();
    cyc_mid();
    cyc_begin();
    rst = 1'b1;
    model_clear();
    cyc_mid();
  endtask

  task automatic test_i_fill();
    logic [6:0] got, exp;
    bit en, we, dn, st;
    cyc_begin();
    i_miss = 1'b1;
    i_addr = 16'h1234;
    cyc_mid();
    checks++;
    if ({stall, mem_en} !== 2'b10) begin
      errors++;
      $display("FAIL ifill_req_cycle got=%b exp=10", {stall, mem_en});
    end
    for (int k = 1; k <= 13; k++) begin
      cyc_begin();
      if (k == 13) i_miss = 1'b0;
      cyc_mid();
      en  = (k <= 8);
      we  = (k >= 5 && k <= 12);
      dn  = (k == 12);
      st  = (k <= 12);
      got = {stall, mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done};
      exp = {st, en, 1'b0, we, 1'b0, dn, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ifill_ctrl k=%0d got=%b exp=%b", k, got, exp);
      end
      if (en) begin
        checks++;
        if (mem_addr !== 16'h1230 + 16'(2 * (k - 1))) begin
          errors++;
          $display("FAIL ifill_addr k=%0d got=%h exp=%h", k, mem_addr,
                   16'h1230 + 16'(2 * (k - 1)));
        end
      end
      if (we) begin
        checks++;
        if ({fill_word, fill_data} !== {3'(k - 5), 16'hA000 + 16'(k - 5)}) begin
          errors++;
          $display("FAIL ifill_data k=%0d got=%0d/%h exp=%0d/%h", k, fill_word, fill_data,
                   k - 5, 16'hA000 + 16'(k - 5));
        end
      end
    end
  endtask

  task automatic test_store();
    cyc_begin();
    d_wr    = 1'b1;
    d_addr  = 16'h00F2;
    d_wdata = 16'hBEEF;
    cyc_mid();
    checks++;
    if ({stall, mem_en, d_done} !== 3'b100) begin
      errors++;
      $display("FAIL store_req got=%b exp=100", {stall, mem_en, d_done});
    end
    cyc_begin();
    cyc_mid();
    checks++;
    if ({stall, mem_en, mem_wr, d_done, i_done, mem_addr, mem_wdata} !==
        {5'b11110, 16'h00F2, 16'hBEEF}) begin
      errors++;
      $display("FAIL store_write got=%b/%h/%h exp=11110/00f2/beef",
               {stall, mem_en, mem_wr, d_done, i_done}, mem_addr, mem_wdata);
    end
    cyc_begin();
    d_wr = 1'b0;
    cyc_mid();
    checks++;
    if ({stall, mem_en, d_done} !== 3'b000) begin
      errors++;
      $display("FAIL store_release got=%b exp=000", {stall, mem_en, d_done});
    end
  endtask

  task automatic test_contention();
    logic [6:0]  got, exp;
    logic [15:0] base;
    bit side_d, en, we, dn, st;
    int j;
    cyc_begin();
    i_miss = 1'b1;
    d_miss = 1'b1;
    i_addr = 16'h0040;
    d_addr = 16'h8010;
    cyc_mid();
    for (int k = 1; k <= 26; k++) begin
      cyc_begin();
      if (k == 13) d_miss = 1'b0;
      if (k == 26) i_miss = 1'b0;
      cyc_mid();
      side_d = (k <= 13);
      j      = side_d ? k : k - 13;
      base   = side_d ? 16'h8010 : 16'h0040;
      en     = (j >= 1 && j <= 8);
      we     = (j >= 5 && j <= 12);
      dn     = (j == 12);
      st     = (k <= 25);
      got = {stall, mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done};
      exp = {st, en, 1'b0, we && !side_d, we && side_d, dn && !side_d, dn && side_d};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL contention_ctrl k=%0d got=%b exp=%b", k, got, exp);
      end
      if (en) begin
        checks++;
        if (mem_addr !== base + 16'(2 * (j - 1))) begin
          errors++;
          $display("FAIL contention_addr k=%0d got=%h exp=%h", k, mem_addr,
                   base + 16'(2 * (j - 1)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [6:0] got, exp;
    bit en, we, dn, st;
    cyc_begin();
    i_miss = 1'b1;
    i_addr = 16'h1234;
    cyc_mid();
    for (int k = 1; k <= 7; k++) begin
      cyc_begin();
      cyc_mid();
    end
    cyc_begin();
    rst    = 1'b0;
    i_miss = 1'b0;
    cyc_mid();
    checks++;
    if ({stall, mem_en, i_fill_we, fill_word, i_done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b exp=0", {stall, mem_en, i_fill_we, fill_word, i_done});
    end
    cyc_begin();
    rst = 1'b1;
    cyc_mid();
    // Responses to reads issued before the reset keep arriving here.
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      cyc_mid();
      checks++;
      if ({stall, mem_en, i_fill_we, d_fill_we, fill_word, fill_data, i_done} !== '0) begin
        errors++;
        $display("FAIL midreset_late_valid k=%0d valid=%b we=%b word=%0d data=%h", k, mem_valid,
                 i_fill_we, fill_word, fill_data);
      end
    end
    cyc_begin();
    i_miss = 1'b1;
    cyc_mid();
    for (int k = 1; k <= 13; k++) begin
      cyc_begin();
      if (k == 13) i_miss = 1'b0;
      cyc_mid();
      en  = (k <= 8);
      we  = (k >= 5 && k <= 12);
      dn  = (k == 12);
      st  = (k <= 12);
      got = {stall, mem_en, mem_wr, i_fill_we, d_fill_we, i_done, d_done};
      exp = {st, en, 1'b0, we, 1'b0, dn, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midreset_refill_ctrl k=%0d got=%b exp=%b", k, got, exp);
      end
      if (en) begin
        checks++;
        if (mem_addr !== 16'h1230 + 16'(2 * (k - 1))) begin
          errors++;
          $display("FAIL midreset_refill_addr k=%0d got=%h", k, mem_addr);
        end
      end
      if (we) begin
        checks++;
        if (fill_word !== 3'(k - 5)) begin
          errors++;
          $display("FAIL midreset_refill_word k=%0d got=%0d exp=%0d", k, fill_word, k - 5);
        end
      end
    end
  endtask

  task automatic test_variable_latency();
    bit side_d, fin;
    logic we, dn, other_we;
    logic [15:0] base;
    int rx, done_cyc, exp_cyc;
    for (int p = 0; p < 2; p++) begin
      model_clear();
      lat      = 1;
      gap_mode = (p == 1);
      side_d   = (p == 1);
      base     = side_d ? 16'h3000 : 16'h2000;
      exp_cyc  = side_d ? 23 : 9;
      cyc_begin();
      if (side_d) begin
        d_miss = 1'b1;
        d_addr = 16'h3006;
      end else begin
        i_miss = 1'b1;
        i_addr = 16'h2008;
      end
      cyc_mid();
      rx       = 0;
      fin      = 1'b0;
      done_cyc = 0;
      for (int c = 1; c <= 60 && !fin; c++) begin
        cyc_begin();
        cyc_mid();
        we       = side_d ? d_fill_we : i_fill_we;
        dn       = side_d ? d_done : i_done;
        other_we = side_d ? i_fill_we : d_fill_we;
        checks++;
        if (other_we !== 1'b0) begin
          errors++;
          $display("FAIL varlat_wrong_side p=%0d c=%0d got=%b exp=0", p, c, other_we);
        end
        if (mem_en === 1'b1) begin
          checks++;
          if (mem_addr !== base + 16'(2 * (c - 1))) begin
            errors++;
            $display("FAIL varlat_addr p=%0d c=%0d got=%h exp=%h", p, c, mem_addr,
                     base + 16'(2 * (c - 1)));
          end
        end
        if (we === 1'b1) begin
          checks++;
          if ({fill_word, fill_data} !== {3'(rx), 16'hA000 + 16'(rx)}) begin
            errors++;
            $display("FAIL varlat_data p=%0d c=%0d got=%0d/%h exp=%0d/%h", p, c, fill_word,
                     fill_data, rx, 16'hA000 + 16'(rx));
          end
          rx++;
        end
        checks++;
        if (dn !== ((we === 1'b1) && rx == 8)) begin
          errors++;
          $display("FAIL varlat_done p=%0d c=%0d got=%b rx=%0d", p, c, dn, rx);
        end
        if (dn === 1'b1) begin
          fin      = 1'b1;
          done_cyc = c;
        end
      end
      checks++;
      if (done_cyc != exp_cyc) begin
        errors++;
        $display("FAIL varlat_done_cycle p=%0d got=%0d exp=%0d", p, done_cyc, exp_cyc);
      end
      cyc_begin();
      i_miss = 1'b0;
      d_miss = 1'b0;
      cyc_mid();
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL varlat_stall_release p=%0d got=%b exp=0", p, stall);
      end
    end
    gap_mode = 1'b0;
    lat      = 4;
  endtask

  initial begin
    rst     = 1'b0;
    i_miss  = 1'b0;
    i_addr  = 16'h0;
    d_miss  = 1'b0;
    d_addr  = 16'h0;
    d_wr    = 1'b0;
    d_wdata = 16'h0;
    model_clear();
    test_reset();
    test_i_fill();
    test_store();
    test_contention();
    test_reset_mid_fill();
    test_variable_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
